toaplan2_pcm_arbiter: RTL and testbench

TOAPLAN2_PCM_ARBITER -- requirements
Module: toaplan2_pcm_arbiter

---
 rtl/toaplan2_pcm_arbiter.sv | 130 +++++++++++++
 tb/tb_toaplan2_pcm_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/toaplan2_pcm_arbiter.sv
// Shares one PCM sample ROM between two OKI requesters, each fronted by a one-entry byte cache.
// Grant to fill is SETTLE+2 cycles; a requester's OK stays low while it waits, and WAIT has no timeout.
module toaplan2_pcm_arbiter #(
  parameter int AW     = 18,
  parameter int BW     = 2,
  parameter int SETTLE = 1
) (
  input  logic             CLK96,
  input  logic             RESET96_N,
  input  logic [AW-1:0]    A_ADDR,
  input  logic [AW-1:0]    B_ADDR,
  input  logic [BW-1:0]    A_BANK,
  input  logic [BW-1:0]    B_BANK,
  output logic [7:0]       A_DOUT,
  output logic [7:0]       B_DOUT,
  output logic             A_OK,
  output logic             B_OK,
  output logic             PCM_CS,
  output logic [AW+BW-1:0] PCM_ADDR,
  input  logic [7:0]       PCM_DOUT,
  input  logic             PCM_OK
);

  localparam int TW = AW + BW;
  localparam int CW = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] settle_cnt;
  logic          gnt_b;
  logic          last_b;

  logic          a_vld;
  logic [TW-1:0] a_tag;
  logic [7:0]    a_dat;
  logic          b_vld;
  logic [TW-1:0] b_tag;
  logic [7:0]    b_dat;

  logic [TW-1:0] a_key;
  logic [TW-1:0] b_key;
  logic          pend_a;
  logic          pend_b;
  logic          grant;
  logic          grant_b;
  logic          issue_done;
  logic          fill;

  assign a_key  = {A_BANK, A_ADDR};
  assign b_key  = {B_BANK, B_ADDR};
  assign A_OK   = a_vld && (a_tag == a_key);
  assign B_OK   = b_vld && (b_tag == b_key);
  assign A_DOUT = a_dat;
  assign B_DOUT = b_dat;
  assign pend_a = !A_OK;
  assign pend_b = !B_OK;

  // Both pending: the loser of the previous contest wins this one.
  assign grant      = (state == ST_IDLE) && (pend_a || pend_b);
  assign grant_b    = pend_b && (!pend_a || !last_b);
  assign issue_done = (settle_cnt == CW'(SETTLE - 1));
  assign fill       = (state == ST_WAIT) && PCM_OK;

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant)      state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_done) state_nxt = ST_WAIT;
      ST_WAIT:  if (PCM_OK)     state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    PCM_CS = 1'b0;
    if (state != ST_IDLE) PCM_CS = 1'b1;
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      PCM_ADDR   <= '0;
      gnt_b      <= 1'b0;
      last_b     <= 1'b1;
      settle_cnt <= '0;
      a_vld      <= 1'b0;
      a_tag      <= '0;
      a_dat      <= '0;
      b_vld      <= 1'b0;
      b_tag      <= '0;
      b_dat      <= '0;
    end else begin
      if (grant) begin
        PCM_ADDR <= grant_b ? b_key : a_key;
        gnt_b    <= grant_b;
        // The pointer only moves on a contested grant, so a lone request does not cost the other its turn.
        if (pend_a && pend_b) last_b <= grant_b;
      end
      if (state == ST_ISSUE) begin
        settle_cnt <= issue_done ? '0 : settle_cnt + 1'b1;
      end
      // The fill uses the latched tag; a requester that moved on simply misses and re-pends.
      if (fill) begin
        if (gnt_b) begin
          b_vld <= 1'b1;
          b_tag <= PCM_ADDR;
          b_dat <= PCM_DOUT;
        end else begin
          a_vld <= 1'b1;
          a_tag <= PCM_ADDR;
          a_dat <= PCM_DOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_toaplan2_pcm_arbiter.sv
// Directed-vector bench for toaplan2_pcm_arbiter at default parameters (AW=18, BW=2, SETTLE=1).
module tb_toaplan2_pcm_arbiter;

  logic        CLK96 = 1'b0;
  logic        RESET96_N;
  logic [17:0] A_ADDR, B_ADDR;
  logic [1:0]  A_BANK, B_BANK;
  logic [7:0]  A_DOUT, B_DOUT;
  logic        A_OK, B_OK;
  logic        PCM_CS;
  logic [19:0] PCM_ADDR;
  logic [7:0]  PCM_DOUT;
  logic        PCM_OK;

  int errors = 0;
  int checks = 0;

  toaplan2_pcm_arbiter dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .A_ADDR(A_ADDR), .B_ADDR(B_ADDR), .A_BANK(A_BANK), .B_BANK(B_BANK),
    .A_DOUT(A_DOUT), .B_DOUT(B_DOUT), .A_OK(A_OK), .B_OK(B_OK),
    .PCM_CS(PCM_CS), .PCM_ADDR(PCM_ADDR), .PCM_DOUT(PCM_DOUT), .PCM_OK(PCM_OK)
  );

  always #5 CLK96 = ~CLK96;

  task automatic tick;
    @(posedge CLK96);
    #1;
  endtask

  task automatic test_reset;
    RESET96_N = 1'b0; A_ADDR = 18'h0; B_ADDR = 18'h0; A_BANK = 2'd0; B_BANK = 2'd0;
    PCM_OK = 1'b1; PCM_DOUT = 8'hFF;
    tick; tick; #1;
    checks++; if (PCM_CS !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", PCM_CS); end
    checks++; if (PCM_ADDR !== 20'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000", PCM_ADDR); end
    checks++; if (A_OK !== 1'b0 || B_OK !== 1'b0) begin errors++; $display("FAIL rst_ok: got %b%b want 00", A_OK, B_OK); end
    checks++; if (A_DOUT !== 8'h0 || B_DOUT !== 8'h0) begin errors++; $display("FAIL rst_dout: got %h/%h want 00/00", A_DOUT, B_DOUT); end
    PCM_OK = 1'b0; PCM_DOUT = 8'h00;
  endtask

  task automatic test_single_fill;
    RESET96_N = 1'b0; A_ADDR = 18'h00010; A_BANK = 2'd1; B_ADDR = 18'h0; B_BANK = 2'd0;
    tick; tick;
    RESET96_N = 1'b1;                 // cycle N: grant A
    tick; #1;                         // ISSUE
    checks++; if (PCM_CS !== 1'b1) begin errors++; $display("FAIL sf_cs_issue: got %b want 1", PCM_CS); end
    checks++; if (PCM_ADDR !== 20'h40010) begin errors++; $display("FAIL sf_addr: got %h want 40010", PCM_ADDR); end
    tick; tick; tick; #1;             // still WAIT, no timeout
    checks++; if (PCM_CS !== 1'b1 || A_OK !== 1'b0) begin errors++; $display("FAIL sf_wait: got cs=%b ok=%b want cs=1 ok=0", PCM_CS, A_OK); end
    PCM_OK = 1'b1; PCM_DOUT = 8'h5A;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b1) begin errors++; $display("FAIL sf_a_ok: got %b want 1", A_OK); end
    checks++; if (A_DOUT !== 8'h5A) begin errors++; $display("FAIL sf_a_dout: got %h want 5a", A_DOUT); end
    checks++; if (PCM_CS !== 1'b0) begin errors++; $display("FAIL sf_cs_idle: got %b want 0", PCM_CS); end
  endtask

  task automatic test_round_robin;
    RESET96_N = 1'b0; A_ADDR = 18'h00100; B_ADDR = 18'h00200; A_BANK = 2'd0; B_BANK = 2'd0;
    tick; tick;
    RESET96_N = 1'b1;                 // both pending, A wins
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00100) begin errors++; $display("FAIL rr_first: got %h want 00100", PCM_ADDR); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h11;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b1 || A_DOUT !== 8'h11 || B_OK !== 1'b0) begin errors++; $display("FAIL rr_a_fill: got ok=%b%b d=%h want 10 11", A_OK, B_OK, A_DOUT); end
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00200 || PCM_CS !== 1'b1) begin errors++; $display("FAIL rr_second: got %h cs=%b want 00200 cs=1", PCM_ADDR, PCM_CS); end
    checks++; if (A_OK !== 1'b1) begin errors++; $display("FAIL rr_a_kept: got %b want 1", A_OK); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h22;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (B_OK !== 1'b1 || B_DOUT !== 8'h22 || A_OK !== 1'b1) begin errors++; $display("FAIL rr_b_fill: got ok=%b%b d=%h want 11 22", A_OK, B_OK, B_DOUT); end
    A_ADDR = 18'h00101; B_ADDR = 18'h00201; #1;
    checks++; if (A_OK !== 1'b0 || B_OK !== 1'b0) begin errors++; $display("FAIL rr_both_miss: got %b%b want 00", A_OK, B_OK); end
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00201) begin errors++; $display("FAIL rr_third_b: got %h want 00201", PCM_ADDR); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h33;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (B_OK !== 1'b1 || B_DOUT !== 8'h33 || A_OK !== 1'b0) begin errors++; $display("FAIL rr_b2_fill: got ok=%b%b d=%h want 01 33", A_OK, B_OK, B_DOUT); end
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00101) begin errors++; $display("FAIL rr_fourth_a: got %h want 00101", PCM_ADDR); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h44;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b1 || A_DOUT !== 8'h44) begin errors++; $display("FAIL rr_a2_fill: got ok=%b d=%h want 1 44", A_OK, A_DOUT); end
  endtask

  task automatic test_stale_ok;
    RESET96_N = 1'b0; A_ADDR = 18'h00300; B_ADDR = 18'h00400; A_BANK = 2'd0; B_BANK = 2'd0;
    PCM_OK = 1'b1; PCM_DOUT = 8'h77;
    tick; tick;
    RESET96_N = 1'b1;                 // N: grant A
    tick; #1;                         // N+1 ISSUE, OK ignored
    checks++; if (A_OK !== 1'b0 || PCM_ADDR !== 20'h00300) begin errors++; $display("FAIL so_issue: got ok=%b addr=%h want 0 00300", A_OK, PCM_ADDR); end
    tick; #1;                         // N+2 WAIT
    checks++; if (A_OK !== 1'b0) begin errors++; $display("FAIL so_early: got %b want 0", A_OK); end
    tick; PCM_DOUT = 8'h78; #1;       // N+3
    checks++; if (A_OK !== 1'b1 || A_DOUT !== 8'h77) begin errors++; $display("FAIL so_fill: got ok=%b d=%h want 1 77", A_OK, A_DOUT); end
    tick; tick; tick; #1;
    checks++; if (B_OK !== 1'b1 || B_DOUT !== 8'h78) begin errors++; $display("FAIL so_b_fill: got ok=%b d=%h want 1 78", B_OK, B_DOUT); end
    PCM_OK = 1'b0;
  endtask

  task automatic test_addr_change_and_bank;
    RESET96_N = 1'b0; A_ADDR = 18'h00004; B_ADDR = 18'h00010; A_BANK = 2'd0; B_BANK = 2'd0;
    tick; tick;
    RESET96_N = 1'b1;
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00004) begin errors++; $display("FAIL ac_issue: got %h want 00004", PCM_ADDR); end
    tick; A_ADDR = 18'h00005; PCM_OK = 1'b1; PCM_DOUT = 8'h55;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b0 || A_DOUT !== 8'h55) begin errors++; $display("FAIL ac_stale: got ok=%b d=%h want 0 55", A_OK, A_DOUT); end
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00010) begin errors++; $display("FAIL ac_b_turn: got %h want 00010", PCM_ADDR); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h66;
    tick; PCM_OK = 1'b0;
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00005 || PCM_CS !== 1'b1) begin errors++; $display("FAIL ac_refetch: got %h cs=%b want 00005 cs=1", PCM_ADDR, PCM_CS); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h56;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b1 || A_DOUT !== 8'h56) begin errors++; $display("FAIL ac_new_fill: got ok=%b d=%h want 1 56", A_OK, A_DOUT); end
    A_BANK = 2'd1; #1;
    checks++; if (A_OK !== 1'b0) begin errors++; $display("FAIL bk_drop: got %b want 0", A_OK); end
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h40005) begin errors++; $display("FAIL bk_refetch: got %h want 40005", PCM_ADDR); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'h99;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b1 || A_DOUT !== 8'h99 || B_OK !== 1'b1) begin errors++; $display("FAIL bk_fill: got ok=%b%b d=%h want 11 99", A_OK, B_OK, A_DOUT); end
  endtask

  task automatic test_reset_mid;
    A_ADDR = 18'h00007; A_BANK = 2'd0;
    tick; tick; PCM_DOUT = 8'hEE;     // WAIT for A
    #2 RESET96_N = 1'b0; #1;
    checks++; if (PCM_CS !== 1'b0) begin errors++; $display("FAIL rm_cs: got %b want 0", PCM_CS); end
    checks++; if (A_OK !== 1'b0 || B_OK !== 1'b0 || A_DOUT !== 8'h0) begin errors++; $display("FAIL rm_ok: got %b%b d=%h want 00 00", A_OK, B_OK, A_DOUT); end
    tick;
    RESET96_N = 1'b1;
    tick; #1;
    checks++; if (PCM_ADDR !== 20'h00007 || PCM_CS !== 1'b1) begin errors++; $display("FAIL rm_regrant: got %h cs=%b want 00007 cs=1", PCM_ADDR, PCM_CS); end
    tick; PCM_OK = 1'b1; PCM_DOUT = 8'hAB;
    tick; PCM_OK = 1'b0; #1;
    checks++; if (A_OK !== 1'b1 || A_DOUT !== 8'hAB || B_OK !== 1'b0) begin errors++; $display("FAIL rm_fill: got ok=%b%b d=%h want 10 ab", A_OK, B_OK, A_DOUT); end
  endtask

  initial begin
    test_reset;
    test_single_fill;
    test_round_robin;
    test_stale_ok;
    test_addr_change_and_bank;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
